// File: rtl/div_pkg.sv
// Shared types and constants for the divider: FSM states, iteration count,
// DivDest bit positions and an operand-magnitude helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_WB
    } div_state_e;

    localparam int DIV_ITER    = 32;

    localparam int DEST_ACC_HI = 3;
    localparam int DEST_ACC_LO = 2;
    localparam int DEST_HI_WE  = 1;
    localparam int DEST_LO_WE  = 0;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, shift the result bit into the quotient.
module div_step
    import div_pkg::*;
(
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] dvsr,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic        fits;

    // When the divisor fits, the difference is below the divisor, so 32-bit
    // modular subtraction is exact even if shifted[32] is set.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        fits    = (shifted >= {1'b0, dvsr});
        rem_out = fits ? (shifted[31:0] - dvsr) : shifted[31:0];
        quo_out = {quo_in[30:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (signed or unsigned) writing quotient and
// remainder to an accumulator pair.
//
// state | meaning
// IDLE  | waiting for an accepted Div_Start
// CALC  | one restoring step per non-held cycle, 32 steps
// FIX   | sign correction of quotient and remainder
// WB    | single-cycle accumulator write
module div_unit
    import div_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_D1_R_N,
    input  logic        Div_Start,
    input  logic        Div_Signed,
    input  logic [1:0]  Div_Acc,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Rhold,
    input  logic        Xcpn,
    output logic [39:0] DDATAHI,
    output logic [39:0] DDATALO,
    output logic [3:0]  DivDest_C1,
    output logic [3:0]  DivDest_C2,
    output logic        Div_Busy
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_ITER - 1);

    div_state_e  state, state_nxt;
    logic [5:0]  step_cnt;
    logic [31:0] rem_q, quo_q, dvsr_q;
    logic [31:0] rem_step, quo_step;
    logic [1:0]  acc_q;
    logic        neg_quo_q, neg_rem_q;
    logic        start_ok;

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvsr    (dvsr_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    assign start_ok = Div_Start && !Rhold && !Xcpn;

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) state <= ST_IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_CALC;
            ST_CALC: begin
                if (Xcpn)                                  state_nxt = ST_IDLE;
                else if (!Rhold && step_cnt == LAST_STEP)  state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = Xcpn ? ST_IDLE : ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            step_cnt  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            acc_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state == ST_IDLE && start_ok) begin
            step_cnt  <= '0;
            rem_q     <= '0;
            quo_q     <= magnitude(SrcA, Div_Signed);
            dvsr_q    <= magnitude(SrcB, Div_Signed);
            acc_q     <= Div_Acc;
            // Zero divisor already yields an all-ones quotient; keep it unnegated.
            neg_quo_q <= Div_Signed && (SrcA[31] ^ SrcB[31]) && (SrcB != 32'd0);
            neg_rem_q <= Div_Signed && SrcA[31];
        end else if (state == ST_CALC && !Rhold) begin
            rem_q    <= rem_step;
            quo_q    <= quo_step;
            step_cnt <= step_cnt + 6'd1;
        end else if (state == ST_FIX) begin
            if (neg_quo_q) quo_q <= ~quo_q + 32'd1;
            if (neg_rem_q) rem_q <= ~rem_q + 32'd1;
        end
    end

    always_comb begin
        DDATAHI    = '0;
        DDATALO    = '0;
        DivDest_C1 = '0;
        DivDest_C2 = '0;
        Div_Busy   = (state != ST_IDLE);
        if (state == ST_WB) begin
            DDATAHI                               = {8'h00, rem_q};
            DDATALO                               = {8'h00, quo_q};
            DivDest_C1[DEST_ACC_HI:DEST_ACC_LO]   = acc_q;
            DivDest_C1[DEST_HI_WE]                = 1'b1;
            DivDest_C1[DEST_LO_WE]                = 1'b1;
            DivDest_C2                            = DivDest_C1;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed results, latency, hold, abort
// and reset behaviour.
module tb_div_unit;

    logic        CLK = 1'b0;
    logic        RESET_D1_R_N;
    logic        Div_Start, Div_Signed, Rhold, Xcpn;
    logic [1:0]  Div_Acc;
    logic [31:0] SrcA, SrcB;
    logic [39:0] DDATAHI, DDATALO;
    logic [3:0]  DivDest_C1, DivDest_C2;
    logic        Div_Busy;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .CLK          (CLK),
        .RESET_D1_R_N (RESET_D1_R_N),
        .Div_Start    (Div_Start),
        .Div_Signed   (Div_Signed),
        .Div_Acc      (Div_Acc),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .Rhold        (Rhold),
        .Xcpn         (Xcpn),
        .DDATAHI      (DDATAHI),
        .DDATALO      (DDATALO),
        .DivDest_C1   (DivDest_C1),
        .DivDest_C2   (DivDest_C2),
        .Div_Busy     (Div_Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // exp_edge = 0 means the operation is expected to abort (no write-back).
    task automatic run_op(input string tag, input bit sgn, input logic [1:0] acc,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold_at, input int hold_len, input int xcpn_at,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_edge);
        int n;
        int wb_n;
        Div_Signed = sgn;
        Div_Acc    = acc;
        SrcA       = a;
        SrcB       = b;
        Div_Start  = 1'b1;
        tick();
        Div_Start  = 1'b0;
        // Scramble inputs to show operands were latched at the start edge.
        SrcA       = 32'hDEAD_BEEF;
        SrcB       = 32'h0000_0013;
        Div_Signed = ~sgn;
        Div_Acc    = ~acc;
        chk({tag, "_busy_start"}, 64'(Div_Busy), 64'd1);
        n    = 0;
        wb_n = -1;
        for (int i = 0; i < 80; i++) begin
            if (exp_edge == 0 && n >= xcpn_at + 2) break;
            Rhold     = (n >= hold_at) && (n < hold_at + hold_len);
            Div_Start = Rhold || (n == 5);
            Xcpn      = (n == xcpn_at);
            tick();
            n++;
            Rhold     = 1'b0;
            Div_Start = 1'b0;
            Xcpn      = 1'b0;
            if (exp_edge == 0 && n == xcpn_at + 1)
                chk({tag, "_busy_abort"}, 64'(Div_Busy), 64'd0);
            if (DivDest_C1 != 4'd0 || DivDest_C2 != 4'd0) begin
                wb_n = n;
                break;
            end
        end
        if (exp_edge == 0) begin
            chk({tag, "_wb_seen"}, 64'(wb_n >= 0), 64'd0);
        end else begin
            chk({tag, "_edge"}, 64'(wb_n + 1), 64'(exp_edge));
            if (wb_n >= 0) begin
                Xcpn = 1'b1;
                #1;
                chk({tag, "_c1"}, 64'(DivDest_C1), 64'({acc, 2'b11}));
                chk({tag, "_c2"}, 64'(DivDest_C2), 64'({acc, 2'b11}));
                chk({tag, "_lo"}, 64'(DDATALO), 64'({8'h00, exp_lo}));
                chk({tag, "_hi"}, 64'(DDATAHI), 64'({8'h00, exp_hi}));
                chk({tag, "_busy_wb"}, 64'(Div_Busy), 64'd1);
                tick();
                Xcpn = 1'b0;
                chk({tag, "_busy_idle"}, 64'(Div_Busy), 64'd0);
                chk({tag, "_c1_idle"}, 64'(DivDest_C1), 64'd0);
                chk({tag, "_lo_idle"}, 64'(DDATALO), 64'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_D1_R_N = 1'b0;
        Div_Start    = 1'b0;
        Div_Signed   = 1'b0;
        Div_Acc      = 2'd0;
        SrcA         = '0;
        SrcB         = '0;
        Rhold        = 1'b0;
        Xcpn         = 1'b0;
        #2;
        chk("rst_busy", 64'(Div_Busy), 64'd0);
        chk("rst_c1", 64'(DivDest_C1), 64'd0);
        chk("rst_c2", 64'(DivDest_C2), 64'd0);
        chk("rst_lo", 64'(DDATALO), 64'd0);
        chk("rst_hi", 64'(DDATAHI), 64'd0);
        repeat (2) tick();
        RESET_D1_R_N = 1'b1;

        run_op("u100_7",   1'b0, 2'd0, 32'd100,       32'd7,         -1, 0, -1, 32'h0000_000E, 32'h0000_0002, 34);
        run_op("s-7_2",    1'b1, 2'd1, 32'hFFFF_FFF9, 32'd2,         -1, 0, -1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        run_op("u_div0",   1'b0, 2'd2, 32'h0000_1234, 32'd0,         -1, 0, -1, 32'hFFFF_FFFF, 32'h0000_1234, 34);
        run_op("s_ovf",    1'b1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, -1, 32'h8000_0000, 32'h0000_0000, 34);
        run_op("s_div0",   1'b1, 2'd0, 32'hFFFF_FFFB, 32'd0,         -1, 0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 34);
        run_op("u_big",    1'b0, 2'd1, 32'hFFFF_FFFF, 32'd16,        -1, 0, -1, 32'h0FFF_FFFF, 32'h0000_000F, 34);
        run_op("hold",     1'b0, 2'd1, 32'd1000,      32'd33,        10, 5, -1, 32'h0000_001E, 32'h0000_000A, 39);
        run_op("abort",    1'b0, 2'd2, 32'd50,        32'd5,         -1, 0, 20, 32'h0,         32'h0,         0);
        run_op("s7_-2",    1'b1, 2'd2, 32'd7,         32'hFFFF_FFFE, -1, 0, -1, 32'hFFFF_FFFD, 32'h0000_0001, 34);

        // Reset in the middle of an operation, then start on the first edge after release.
        Div_Signed = 1'b0;
        Div_Acc    = 2'd1;
        SrcA       = 32'd77;
        SrcB       = 32'd3;
        Div_Start  = 1'b1;
        tick();
        Div_Start  = 1'b0;
        repeat (15) tick();
        #2;
        RESET_D1_R_N = 1'b0;
        #1;
        chk("midrst_busy", 64'(Div_Busy), 64'd0);
        chk("midrst_c1", 64'(DivDest_C1), 64'd0);
        repeat (2) tick();
        RESET_D1_R_N = 1'b1;
        run_op("post_rst", 1'b0, 2'd3, 32'd100,       32'd7,         -1, 0, -1, 32'h0000_000E, 32'h0000_0002, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
